hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, max number of cycles to wait for MemAckM before error (1..255).
REQ-002 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Rs1D, Rs2D  input  5  source registers of instruction in Decode.
REQ-005 Rs1E, Rs2E  input  5  source registers of instruction in Execute.
REQ-006 RdE, RdM, RdW  input  5  destination registers in Execute, Memory and Writeback.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1  destination write enable per stage.
REQ-008 LoadE  input  1  instruction in Execute is a load.
REQ-009 PCSrcE  input  1  branch/jump taken, resolved in Execute.
REQ-010 MemReqM  input  1  load/store present in Memory stage; MemAckM  input  1  data-memory completion.
REQ-011 StallF, StallD, StallE, StallM  output  1  hold the PC and the IF_ID, ID_EX and EX_MEM registers.
REQ-012 FlushD, FlushE, FlushW  output  1  load a bubble into IF_ID, ID_EX and MEM_WB.
REQ-013 ForwardAE, ForwardBE  output  2  operand select: 00 register file, 01 Writeback result, 10 ALUResultM.
REQ-014 MemTimeout  output  1  sticky error flag; StallCycles  output  16  saturating stall counter.

Function
REQ-015 Memory FSM states: M_IDLE, M_WAIT, M_ERR; reset state M_IDLE.
REQ-016 M_IDLE: MemReqM=1 and MemAckM=0 -> M_WAIT; MemReqM=1 and MemAckM=1 in the same cycle -> stay M_IDLE with no stall.
REQ-017 M_WAIT: MemAckM=1 -> M_IDLE, with the stall deasserted combinationally in the ack cycle; otherwise wait counter increments.
REQ-018 M_WAIT with wait counter equal to TIMEOUT and no ack -> M_ERR; M_ERR is left only by reset.
REQ-019 memStall = (M_IDLE & MemReqM & ~MemAckM) | (M_WAIT & ~MemAckM) | M_ERR.
REQ-020 memStall=1 -> StallF, StallD, StallE and StallM are all 1, FlushW=1, and FlushD and FlushE are forced to 0.
REQ-021 Load-use: lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-022 When memStall=0: StallF = StallD = lwStall|rawStall; FlushE = lwStall|rawStall|PCSrcE; FlushD = PCSrcE.
REQ-023 Taken branch and load-use in the same cycle -> FlushD=1, FlushE=1, StallD=1 (the branch squashes the stalled instruction).
REQ-024 StallE=StallM=FlushW=0 whenever memStall=0.
REQ-025 Wait counter is 8 bits, cleared on every entry to M_WAIT, never wraps.
REQ-026 StallCycles increments every cycle in which StallF=1 and saturates at 16'hFFFF.
REQ-027 MemTimeout=1 exactly while in M_ERR.

Reset
REQ-028 Reset forces M_IDLE, wait counter 0, StallCycles 0, MemTimeout 0; the combinational outputs then follow their inputs.
REQ-029 Reset asserted mid-wait abandons the access, with no ack tracking after release.

Configuration
REQ-030 Macro HAZARD_FORWARD_EN defined: forwarding is compiled in and rawStall=0.
REQ-031 Forwarding select: 10 if RegWriteM & RdM!=0 & RdM==RsxE; otherwise 01 if RegWriteW & RdW!=0 & RdW==RsxE; otherwise 00. Memory stage has priority.
REQ-032 HAZARD_FORWARD_EN undefined: ForwardAE=ForwardBE=00.
REQ-033 Without the macro, rawStall=1 when Rs1D or Rs2D matches a nonzero RdE (RegWriteE) or RdM (RegWriteM).

Structure
REQ-034 Shared package hazard_pkg holds the memory FSM state enum and the forward-select constants FWD_RF, FWD_WB, FWD_MEM.
REQ-035 One sub-module, hazard_mem_fsm, holds the memory FSM, wait counter and timeout; forwarding and stall logic stay in hazard_ctrl.

Verification
REQ-036 Load-use: LoadE=1, RdE=5, Rs1D=5 -> one cycle of StallF=StallD=FlushE=1, then clear; StallCycles=1.
REQ-037 Branch: PCSrcE=1 -> FlushD=FlushE=1 for one cycle, no stall.
REQ-038 Slow memory: MemReqM=1, ack after 3 cycles -> StallF..StallM=1 for 3 cycles, 0 in the ack cycle, M_IDLE after.
REQ-039 Timeout: TIMEOUT=4, MemReqM=1, no ack -> MemTimeout=1 from the cycle after wait count 4, stalls held; reset clears.
REQ-040 Forwarding (macro defined): RdM=RdW=7, both write enables set, Rs1E=7 -> ForwardAE=10; RdM=0 -> ForwardAE=01.
REQ-041 Memory stall plus branch: MemReqM=1, MemAckM=0, PCSrcE=1 -> FlushD=FlushE=0, all stalls 1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } mem_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // A producer hits a consumer when it writes a nonzero register the consumer reads.
    function automatic logic src_hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory handshake tracker: idle/wait/error FSM with wait counter and sticky timeout.
module hazard_mem_fsm
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_mem_req,
    input  logic i_mem_ack,
    output logic o_mem_stall,
    output logic o_timeout
);

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    mem_state_e r_state;
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= M_IDLE;
            r_wait_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (i_mem_req && !i_mem_ack) begin
                        r_state    <= M_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                M_WAIT: begin
                    if (i_mem_ack) begin
                        r_state <= M_IDLE;
                    end else if (r_wait_cnt == TIMEOUT_C) begin
                        r_state   <= M_ERR;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                M_ERR:   r_state <= M_ERR;
                default: r_state <= M_IDLE;
            endcase
        end
    end

    // The ack releases the stall in the same cycle it arrives.
    assign o_mem_stall = ((r_state == M_IDLE) && i_mem_req && !i_mem_ack) ||
                         ((r_state == M_WAIT) && !i_mem_ack) ||
                         (r_state == M_ERR);
    assign o_timeout   = r_timeout;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use/RAW stalls, branch flushes, memory stalls, forwarding.
// Define HAZARD_FORWARD_EN to compile in operand forwarding (removes RAW stalls).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemAckM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [15:0] StallCycles
);

    logic        w_mem_stall;
    logic        w_lw_stall;
    logic        w_raw_stall;
    logic        w_hz_stall;
    logic [15:0] r_stall_cycles;

    hazard_mem_fsm #(.TIMEOUT(TIMEOUT)) u_mem_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_mem_req   (MemReqM),
        .i_mem_ack   (MemAckM),
        .o_mem_stall (w_mem_stall),
        .o_timeout   (MemTimeout)
    );

    assign w_lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (src_hit(RdM, RegWriteM, rs))      return FWD_MEM;
        else if (src_hit(RdW, RegWriteW, rs)) return FWD_WB;
        else                                  return FWD_RF;
    endfunction

    logic w_unused;
    assign w_unused    = RegWriteE;
    assign w_raw_stall = 1'b0;
    assign ForwardAE   = fwd_sel(Rs1E);
    assign ForwardBE   = fwd_sel(Rs2E);
`else
    // Without forwarding, Decode waits until Execute/Memory producers reach the register file.
    logic w_unused;
    assign w_unused    = ^{RegWriteW, RdW, Rs1E, Rs2E};
    assign w_raw_stall = src_hit(RdE, RegWriteE, Rs1D) || src_hit(RdE, RegWriteE, Rs2D) ||
                         src_hit(RdM, RegWriteM, Rs1D) || src_hit(RdM, RegWriteM, Rs2D);
    assign ForwardAE   = FWD_RF;
    assign ForwardBE   = FWD_RF;
`endif

    assign w_hz_stall = w_lw_stall || w_raw_stall;

    // A memory stall freezes the whole front; flushes would lose the held instructions.
    assign StallF = w_mem_stall || w_hz_stall;
    assign StallD = w_mem_stall || w_hz_stall;
    assign StallE = w_mem_stall;
    assign StallM = w_mem_stall;
    assign FlushW = w_mem_stall;
    assign FlushD = !w_mem_stall && PCSrcE;
    assign FlushE = !w_mem_stall && (w_hz_stall || PCSrcE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cycles <= 16'd0;
        else if (StallF && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCycles;

    hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: outstanding access, cycles already waited, dead memory, stall tally.
    bit m_busy, m_dead;
    int m_waited, m_tally;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] rd, input logic we, input logic [4:0] rs);
        return we && rd != 0 && rd == rs;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
`ifdef HAZARD_FORWARD_EN
        if (hit(RdM, RegWriteM, rs)) return 2'b10;
        if (hit(RdW, RegWriteW, rs)) return 2'b01;
`endif
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemAckM} = '0;
    endtask

    // Called at posedge+1: check combinational view mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag);
        bit mem, lw, raw, hz, sf;
        logic [6:0] ev;
        #2;
        mem = m_dead || (m_busy && !MemAckM) || (!m_busy && MemReqM && !MemAckM);
        lw  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        raw = 1'b0;
`ifndef HAZARD_FORWARD_EN
        raw = hit(RdE, RegWriteE, Rs1D) || hit(RdE, RegWriteE, Rs2D) ||
              hit(RdM, RegWriteM, Rs1D) || hit(RdM, RegWriteM, Rs2D);
`endif
        hz = lw || raw;
        sf = mem || hz;
        ev = {sf, sf, mem, mem, !mem && PCSrcE, !mem && (hz || PCSrcE), mem};
        chk({tag, "_ctl"}, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, ev});
        chk({tag, "_fwa"}, {30'd0, ForwardAE}, {30'd0, exp_fwd(Rs1E)});
        chk({tag, "_fwb"}, {30'd0, ForwardBE}, {30'd0, exp_fwd(Rs2E)});
        chk({tag, "_to"}, {31'd0, MemTimeout}, {31'd0, m_dead});
        chk({tag, "_cnt"}, {16'd0, StallCycles}, m_tally);
        @(posedge clk);
        if (!m_dead) begin
            if (m_busy) begin
                if (MemAckM)             m_busy = 1'b0;
                else if (m_waited == TO) m_dead = 1'b1;
                else                     m_waited++;
            end else if (MemReqM && !MemAckM) begin
                m_busy   = 1'b1;
                m_waited = 0;
            end
        end
        if (sf && m_tally < 65535) m_tally++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_to", {31'd0, MemTimeout}, 32'd0);
        chk("rst_cnt", {16'd0, StallCycles}, 32'd0);
        m_busy = 0; m_dead = 0; m_waited = 0; m_tally = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("init_to", {31'd0, MemTimeout}, 32'd0);
        chk("init_cnt", {16'd0, StallCycles}, 32'd0);
        chk("init_stf", {31'd0, StallF}, 32'd0);
        do_reset();

        // Load-use: one stall cycle, then clear.
        LoadE = 1; RegWriteE = 1; RdE = 5; Rs1D = 5;
        cycle("lu");
        idle_inputs();
        cycle("lu_after");
        chk("lu_cnt", {16'd0, StallCycles}, 32'd1);

        // Taken branch alone, then together with load-use.
        PCSrcE = 1;
        cycle("br");
        LoadE = 1; RdE = 3; Rs2D = 3;
        #2;
        chk("br_lu_fd", {31'd0, FlushD}, 32'd1);
        chk("br_lu_sd", {31'd0, StallD}, 32'd1);
        #1; @(posedge clk); m_tally++; #1;
        idle_inputs();

        // Slow memory: ack on the fourth cycle.
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            #2 chk("slow_sm", {31'd0, StallM}, 32'd1);
            #1; cycle("slow");
        end
        MemAckM = 1;
        #2 chk("slow_ack_sf", {31'd0, StallF}, 32'd0);
        #1; cycle("slow_ack");
        idle_inputs();
        cycle("slow_idle");

        // Memory stall masks a taken branch.
        MemReqM = 1; PCSrcE = 1;
        #2;
        chk("mb_fd", {31'd0, FlushD}, 32'd0);
        chk("mb_fe", {31'd0, FlushE}, 32'd0);
        #1; cycle("mb");
        idle_inputs();

        // Timeout: wait counts 0..TO then error, sticky until reset.
        do_reset();
        MemReqM = 1;
        for (int i = 0; i < TO + 1; i++) cycle("to_wait");
        chk("to_pre", {31'd0, MemTimeout}, 32'd0);
        cycle("to_last");
        chk("to_set", {31'd0, MemTimeout}, 32'd1);
        MemReqM = 0; MemAckM = 1;
        cycle("to_hold");
        chk("to_stick_sm", {31'd0, StallM}, 32'd1);
        idle_inputs();
        do_reset();
        cycle("to_clr");

        // Reset mid-wait abandons the access.
        MemReqM = 1;
        cycle("mid_a");
        cycle("mid_b");
        MemReqM = 0;
        do_reset();
        cycle("mid_after");

        // Forwarding priority.
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
        cycle("fwd_mem");
        RdM = 0;
        cycle("fwd_wb");
`ifdef HAZARD_FORWARD_EN
        chk("fwd_wb_ae", {30'd0, ForwardAE}, 32'd1);
`else
        chk("fwd_off_ae", {30'd0, ForwardAE}, 32'd0);
`endif
        idle_inputs();

        // Random traffic with small register space to provoke matches.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            LoadE   = ($urandom_range(0, 3) == 0);
            PCSrcE  = ($urandom_range(0, 4) == 0);
            MemReqM = ($urandom_range(0, 3) == 0);
            MemAckM = ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
